// File: rtl/mandelbrot_pkg.sv
// Shared fixed-point layout, constants and FSM state encoding for the Mandelbrot datapath.
package mandelbrot_pkg;

  localparam int FP_S = 1;
  localparam int FP_I = 4;

  // Fraction bits of an s4.F word of the given total width.
  function automatic int fp_frac(input int fpw);
    return fpw - FP_S - FP_I;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_M3   = 3'd4,
    ST_M4   = 3'd5,
    ST_UPD  = 3'd6,
    ST_OUT  = 3'd7
  } state_t;

endpackage

// File: rtl/mandelbrot_if.sv
// Point-in / result-out valid-ready streams of the Mandelbrot iterator.
interface mandelbrot_if #(
  parameter int FPW = 27,
  parameter int AW  = 12,
  parameter int IW  = 8
);
  logic           in_vld;
  logic           in_rdy;
  logic [FPW-1:0] in_x;
  logic [FPW-1:0] in_y;
  logic [AW-1:0]  in_adr;
  logic           out_vld;
  logic           out_rdy;
  logic [AW-1:0]  out_adr;
  logic [IW-1:0]  out_dat;

  modport master (
    output in_vld, in_x, in_y, in_adr, out_rdy,
    input  in_rdy, out_vld, out_adr, out_dat
  );

  modport slave (
    input  in_vld, in_x, in_y, in_adr, out_rdy,
    output in_rdy, out_vld, out_adr, out_dat
  );
endinterface

// File: rtl/mandelbrot_mul.sv
// Registered signed FPW x FPW multiply, product rescaled to s8.F (FPW+4 bits).
module mandelbrot_mul
  import mandelbrot_pkg::*;
#(
  parameter int FPW = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic signed [FPW-1:0] a,
  input  logic signed [FPW-1:0] b,
  output logic signed [FPW+3:0] p
);
  localparam int F  = fp_frac(FPW);
  localparam int PW = FPW + 4;
  localparam int XW = 2 * FPW;

  logic signed [PW-1:0] p_reg;

  // Operands bounded by the escape test, so dropping the top product bits never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
    end else if (clk_en) begin
      p_reg <= PW'((XW'(a) * XW'(b)) >>> F);
    end
  end

  assign p = p_reg;
endmodule

// File: rtl/mandelbrot_calc.sv
// Mandelbrot escape-time iterator: accepts a point, iterates z <- z^2 + c on one shared multiplier,
// reports the iteration count with the pixel address.
module mandelbrot_calc
  import mandelbrot_pkg::*;
#(
  parameter int FPW     = 27,
  parameter int AW      = 12,
  parameter int IW      = 8,
  parameter int MAXITER = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  mandelbrot_if.slave bus
);
  localparam int F  = fp_frac(FPW);
  localparam int PW = FPW + 4;
  localparam int SW = FPW + 5;

  typedef logic signed [FPW-1:0] fp_t;
  typedef logic signed [PW-1:0]  prod_t;
  typedef logic signed [SW-1:0]  sum_t;

  localparam sum_t FOUR = sum_t'(longint'(4) << F);

  state_t         state_reg;
  fp_t            cx_reg, cy_reg, zx_reg, zy_reg;
  fp_t            op_a_reg, op_b_reg;
  prod_t          xx_reg, yy_reg, xy_reg;
  prod_t          prod;
  logic [AW-1:0]  adr_reg;
  logic [IW-1:0]  niter_reg;
  logic           out_vld_reg;
  logic [AW-1:0]  out_adr_reg;
  logic [IW-1:0]  out_dat_reg;

  sum_t mag_next;
  fp_t  zx_next, zy_next;
  logic escape_next, stop_next;

  mandelbrot_mul #(.FPW(FPW)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .a      (op_a_reg),
    .b      (op_b_reg),
    .p      (prod)
  );

  // Escape sum and next z are formed one bit wider than the products so nothing wraps.
  always_comb begin
    mag_next    = sum_t'(xx_reg) + sum_t'(yy_reg);
    escape_next = mag_next > FOUR;
    stop_next   = escape_next || (niter_reg == IW'(MAXITER));
    zx_next     = fp_t'(sum_t'(xx_reg) - sum_t'(yy_reg) + sum_t'(cx_reg));
    zy_next     = fp_t'((sum_t'(xy_reg) <<< 1) + sum_t'(cy_reg));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cx_reg      <= '0;
      cy_reg      <= '0;
      zx_reg      <= '0;
      zy_reg      <= '0;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      xx_reg      <= '0;
      yy_reg      <= '0;
      xy_reg      <= '0;
      adr_reg     <= '0;
      niter_reg   <= '0;
      out_vld_reg <= 1'b0;
      out_adr_reg <= '0;
      out_dat_reg <= '0;
    end else if (clk_en) begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_vld) begin
            cx_reg    <= fp_t'(bus.in_x);
            cy_reg    <= fp_t'(bus.in_y);
            adr_reg   <= bus.in_adr;
            zx_reg    <= '0;
            zy_reg    <= '0;
            niter_reg <= '0;
            state_reg <= ST_M0;
          end
        end
        ST_M0: begin
          op_a_reg  <= zx_reg;
          op_b_reg  <= zx_reg;
          state_reg <= ST_M1;
        end
        ST_M1: begin
          op_a_reg  <= zy_reg;
          op_b_reg  <= zy_reg;
          state_reg <= ST_M2;
        end
        ST_M2: begin
          xx_reg    <= prod;
          op_a_reg  <= zx_reg;
          op_b_reg  <= zy_reg;
          state_reg <= ST_M3;
        end
        ST_M3: begin
          yy_reg    <= prod;
          state_reg <= ST_M4;
        end
        ST_M4: begin
          xy_reg    <= prod;
          state_reg <= ST_UPD;
        end
        ST_UPD: begin
          if (stop_next) begin
            out_dat_reg <= niter_reg;
            out_adr_reg <= adr_reg;
            out_vld_reg <= 1'b1;
            state_reg   <= ST_OUT;
          end else begin
            zx_reg    <= zx_next;
            zy_reg    <= zy_next;
            niter_reg <= niter_reg + IW'(1);
            state_reg <= ST_M0;
          end
        end
        ST_OUT: begin
          if (bus.out_rdy) begin
            out_vld_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_rdy  = (state_reg == ST_IDLE);
  assign bus.out_vld = out_vld_reg;
  assign bus.out_adr = out_adr_reg;
  assign bus.out_dat = out_dat_reg;
endmodule

// File: tb/tb_mandelbrot_calc.sv
// Directed and randomized checks of mandelbrot_calc against an arithmetic escape-time model.
module tb_mandelbrot_calc;
  localparam int FPW     = 27;
  localparam int AW      = 12;
  localparam int IW      = 8;
  localparam int MAXITER = 255;
  localparam int F       = 22;
  localparam longint ONE = longint'(1) << F;
  localparam int LIMIT   = 4000;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b1;

  mandelbrot_if #(.FPW(FPW), .AW(AW), .IW(IW)) bus ();

  mandelbrot_calc #(.FPW(FPW), .AW(AW), .IW(IW), .MAXITER(MAXITER)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Sign-extend the low FPW bits, as a FPW-bit register would hold them.
  function automatic longint wrap_fp(input longint v);
    return (v <<< (64 - FPW)) >>> (64 - FPW);
  endfunction

  // Escape-time count straight from the iteration rules, in wide integer arithmetic.
  function automatic int model_iter(input longint cx, input longint cy);
    longint zx = 0;
    longint zy = 0;
    longint xx, yy, xy;
    for (int k = 0; k <= MAXITER; k++) begin
      xx = (zx * zx) >>> F;
      yy = (zy * zy) >>> F;
      xy = (zx * zy) >>> F;
      if ((xx + yy > 4 * ONE) || (k == MAXITER)) return k;
      zx = wrap_fp(xx - yy + cx);
      zy = wrap_fp(2 * xy + cy);
    end
    return MAXITER;
  endfunction

  task automatic drive_point(input longint x, input longint y, input int adr);
    int w = 0;
    while (!bus.in_rdy && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_rdy_before_accept", longint'(bus.in_rdy), 1);
    bus.in_x   = FPW'(x);
    bus.in_y   = FPW'(y);
    bus.in_adr = AW'(adr);
    bus.in_vld = 1'b1;
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_vld && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_case(input string tag, input longint x, input longint y, input int adr,
                          input int exp_n, input int exp_lat);
    int lat;
    drive_point(x, y, adr);
    wait_out(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_dat"}, longint'(bus.out_dat), exp_n);
    check({tag, "_adr"}, longint'(bus.out_adr), adr);
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, longint'(bus.out_vld), 0);
    check({tag, "_rdy_back"}, longint'(bus.in_rdy), 1);
    $display("point %s x=%0d y=%0d adr=%0h -> dat=%0d lat=%0d", tag, x, y, adr, exp_n, lat);
  endtask

  initial begin
    int lat;
    int n;
    longint rx, ry;
    int radr;

    bus.in_vld  = 1'b0;
    bus.in_x    = '0;
    bus.in_y    = '0;
    bus.in_adr  = '0;
    bus.out_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", longint'(bus.in_rdy), 1);
    check("rst_out_vld", longint'(bus.out_vld), 0);
    check("rst_out_adr", longint'(bus.out_adr), 0);
    check("rst_out_dat", longint'(bus.out_dat), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_case("c_zero", 0, 0, 'h005, 255, 1536);
    run_case("c_one", ONE, 0, 'h123, 3, 24);
    run_case("c_far", -(5 * ONE) / 2, -ONE, 'hABC, 1, 12);
    run_case("c_minus2", -2 * ONE, 0, 'hFFF, 255, 1536);

    // Back-pressure: result must hold while the sink stalls, and the input stays closed.
    bus.out_rdy = 1'b0;
    drive_point(ONE, 0, 'h02A);
    wait_out(lat);
    check("bp_latency", lat, 24);
    for (int i = 0; i < 20; i++) begin
      bus.in_vld = i[0];
      bus.in_x   = FPW'($urandom);
      bus.in_adr = AW'($urandom);
      @(posedge clk); #1;
      check("bp_out_vld", longint'(bus.out_vld), 1);
      check("bp_out_dat", longint'(bus.out_dat), 3);
      check("bp_out_adr", longint'(bus.out_adr), 'h02A);
      check("bp_in_rdy", longint'(bus.in_rdy), 0);
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_release_vld", longint'(bus.out_vld), 0);
    check("bp_release_rdy", longint'(bus.in_rdy), 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_no_ghost_vld", longint'(bus.out_vld), 0);
      check("bp_no_ghost_rdy", longint'(bus.in_rdy), 1);
    end
    $display("point backpressure adr=02a -> dat=3 lat=%0d", lat);

    // Clock enable alternating: every other edge is dead, so latency doubles.
    drive_point(ONE, 0, 'h077);
    clk_en = 1'b0;
    lat = 0;
    while (!bus.out_vld && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
      clk_en = ((lat + 1) % 2 == 0);
    end
    check("ce_latency", lat, 48);
    check("ce_dat", longint'(bus.out_dat), 3);
    @(posedge clk); #1;
    check("ce_hold_vld", longint'(bus.out_vld), 1);
    clk_en = 1'b1;
    @(posedge clk); #1;
    check("ce_consume_vld", longint'(bus.out_vld), 0);
    check("ce_consume_rdy", longint'(bus.in_rdy), 1);
    $display("point clk_en_toggle adr=077 -> dat=3 lat=%0d", lat);

    // Reset in the middle of the second pass drops the point.
    drive_point(ONE, 0, 'h0EE);
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", longint'(bus.in_rdy), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", longint'(bus.out_vld), 0);
    check("mid_rst_rdy", longint'(bus.in_rdy), 1);
    check("mid_rst_dat", longint'(bus.out_dat), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_idle_vld", longint'(bus.out_vld), 0);
    run_case("after_rst", ONE, 0, 'h0EF, 3, 24);

    for (int i = 0; i < 24; i++) begin
      rx   = longint'($urandom_range(0, 20971520)) - 10485760;
      ry   = longint'($urandom_range(0, 20971520)) - 10485760;
      radr = int'($urandom_range(0, 4095));
      n    = model_iter(rx, ry);
      run_case("random", rx, ry, radr, n, 6 * (n + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
